// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ID/EX field widths, bit offsets and
// skid-stage state encodings for the elastic pipeline stages.
package pipe_pkg;

  localparam int PC_W  = 32;
  localparam int OP_W  = 32;
  localparam int IMM_W = 12;
  localparam int OPC_W = 7;
  localparam int ALU_W = 1;
  localparam int F7_W  = 7;
  localparam int F3_W  = 3;

  localparam int IDEX_PAYLOAD_W =
    PC_W + 2 * OP_W + IMM_W + OPC_W +
    ALU_W + F7_W + F3_W;

  localparam int F3_LSB  = 0;
  localparam int F7_LSB  = F3_LSB + F3_W;
  localparam int ALU_LSB = F7_LSB + F7_W;
  localparam int OPC_LSB = ALU_LSB + ALU_W;
  localparam int IMM_LSB = OPC_LSB + OPC_W;
  localparam int OP2_LSB = IMM_LSB + IMM_W;
  localparam int OP1_LSB = OP2_LSB + OP_W;
  localparam int PC_LSB  = OP1_LSB + OP_W;

  // {main_valid, skid_valid}; 2'b01 is illegal
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register + valid bit.
// Ports: clk, rst, clr (kill), load (d->q, set valid), drop (valid=0), valid, q.
module pipe_slot #(
  parameter int W = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready stage with flush and optional skid slot.
// Ports: clk, rst, flush, in_valid/in_ready/in_payload, out_valid/out_ready/out_payload, occupancy.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = IDEX_PAYLOAD_W,
  parameter bit SKID = 1'b1,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
);

  logic                 main_v;
  logic [PAYLOAD_W-1:0] main_q;
  logic                 m_load;
  logic                 m_drop;
  logic                 m_clr;
  logic [PAYLOAD_W-1:0] m_d;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

  pipe_slot #(
    .W        (PAYLOAD_W),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (m_clr),
    .load (m_load),
    .drop (m_drop),
    .d    (m_d),
    .valid(main_v),
    .q    (main_q)
  );

  assign out_valid   = main_v;
  assign out_payload = main_q;

  if (SKID) begin : g_skid
    logic                 skid_v;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 s_load;
    logic                 s_clr;
    logic [1:0]           state;

    pipe_slot #(
      .W        (PAYLOAD_W),
      .RESET_VAL(RESET_VAL)
    ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clr  (s_clr),
      .load (s_load),
      .drop (1'b0),
      .d    (in_payload),
      .valid(skid_v),
      .q    (skid_q)
    );

    assign state = {main_v, skid_v};

    always_comb begin
      m_load = 1'b0;
      m_drop = 1'b0;
      m_clr  = 1'b0;
      m_d    = in_payload;
      s_load = 1'b0;
      s_clr  = 1'b0;
      if (flush) begin
        m_clr = 1'b1;
        s_clr = 1'b1;
      end else begin
        unique case (state)
          ST_EMPTY: m_load = in_fire;
          ST_ONE: begin
            if (in_fire && out_fire)
              m_load = 1'b1;
            else if (in_fire)
              s_load = 1'b1;
            else if (out_fire)
              m_drop = 1'b1;
          end
          ST_FULL: begin
            if (out_fire) begin
              m_load = 1'b1;
              m_d    = skid_q;
              s_clr  = 1'b1;
            end
          end
          default: begin
            // 01 cannot be reached; recover to EMPTY
            m_clr = 1'b1;
            s_clr = 1'b1;
          end
        endcase
      end
    end

    // registered-only: no path from out_ready or flush
    always_comb begin
      in_ready  = ~skid_v;
      occupancy = {1'b0, main_v} + {1'b0, skid_v};
    end
  end else begin : g_reg
    always_comb begin
      m_clr  = flush;
      m_load = in_fire;
      m_drop = out_fire;
      m_d    = in_payload;
    end

    always_comb begin
      in_ready  = ~main_v | out_ready;
      occupancy = {1'b0, main_v};
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline stage that replaces the fixed ID/EX register. It carries an opaque payload (the packed ID/EX bundle by default) with a valid/ready handshake, synchronous flush to insert bubbles, and an optional skid slot. The skid slot keeps full throughput while in_ready stays a registered signal. One instance sits between each pair of pipeline stages.

Parameters:
PAYLOAD_W, 126, payload width in bits; default = pc32+op1 32+op2 32+imm12+opcode7+alu_src1+func7 7+func3 3.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
RESET_VAL, 0, payload value after reset and after flush (PAYLOAD_W bits).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous kill of all held entries (branch/jump redirect).
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept this cycle.
in_payload  in  PAYLOAD_W  upstream payload.
out_valid  out  1  main slot holds a valid payload.
out_ready  in  1  downstream accepts this cycle.
out_payload  out  PAYLOAD_W  main-slot payload.
occupancy  out  2  number of valid entries: 0, 1 or 2.

Behaviour:
- Reset (async, rst=1):
  - main_valid=0, skid_valid=0, both payload regs=RESET_VAL.
  - out_valid=0, occupancy=0, out_payload=RESET_VAL.
  - in_ready reads 1; no transfer is taken while rst=1.
  - Reset asserted mid-transfer discards everything.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- SKID=1 states are encoded by (main_valid, skid_valid): EMPTY=00, ONE=10, FULL=11. The encoding 01 is illegal.
- in_ready = ~skid_valid. It is a register output and has no combinational path from out_ready.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main<=in_payload.
  - ONE: in_fire & out_fire -> ONE, main<=in_payload.
  - ONE: in_fire only -> FULL, skid<=in_payload.
  - ONE: out_fire only -> EMPTY.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid, skid<=RESET_VAL.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Sustained throughput is 1/cycle with out_ready=1.
- Ordering: strict FIFO order. A payload never overtakes the skid entry.
- Stability:
  - While out_valid=1 and out_ready=0, out_payload and out_valid hold constant.
  - out_valid never drops without out_fire, flush or rst.
- SKID=0:
  - Only main is used; occupancy is at most 1.
  - in_ready = ~main_valid | out_ready (combinational).
  - main loads whenever in_fire, otherwise clears valid on out_fire.
- Flush:
  - Highest priority after rst.
  - At the next edge: main_valid=0, skid_valid=0, payload regs=RESET_VAL, occupancy=0.
  - An in_fire coinciding with flush is consumed (upstream sees acceptance) and discarded.
  - An out_fire coinciding with flush completes normally downstream; the entry is not duplicated.
  - in_ready does not depend on flush combinationally.
- occupancy = main_valid + skid_valid, registered-derived with no combinational input path.
- All outputs are glitch-free register outputs, except in_ready when SKID=0.

Decomposition:
- Shared package pipe_pkg holds:
  - ID/EX field widths and bit offsets (PC_W=32, OP_W=32, IMM_W=12, OPC_W=7, F7_W=7, F3_W=3) and the derived IDEX_PAYLOAD_W=126.
  - State-encoding localparams ST_EMPTY, ST_ONE, ST_FULL.
- One natural sub-module is pipe_slot: a PAYLOAD_W register plus valid bit with load, clear-to-RESET_VAL and async reset. It is instantiated as main and, when SKID=1, as skid.
- Pack/unpack of ID/EX fields is done by the instantiating stage, not here.

Test Plan:
- Reset: assert rst for 3 cycles with in_valid=1 and payload 0x2A -> out_valid=0, occupancy=0, out_payload=0 throughout. Release rst -> first accept occurs on the next edge.
- Streaming, SKID=1: hold out_ready=1 and drive 8 payloads 1..8 back-to-back -> out_payload is 1..8 on consecutive cycles after 1-cycle latency, and in_ready stays 1.
- Backpressure: out_ready=0 and send A=0x11, B=0x22, C=0x33 -> A and B are accepted, in_ready=0 after B, C is held, occupancy=2, out_payload stays 0x11. Release out_ready -> output order is 0x11, 0x22, 0x33 with none lost.
- Flush while FULL: with occupancy=2, pulse flush together with in_valid=1 and payload 0x44 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x44 never appears on out_payload.
- Simultaneous fires in ONE: main holds 0x55; present in 0x66 with out_ready=1 -> 0x55 is taken, main becomes 0x66, occupancy remains 1.
- SKID=0 build: out_ready=0 with main full -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally in the same cycle and the new payload is loaded at the edge.
